// File: rtl/vliw_uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_uart_pkg
//  Description : Shared constants and FSM state types for the VLIW UART
//                front end (register map, STATUS bit positions, states).
//  Revision    : 1.0  initial release
// ============================================================================
package vliw_uart_pkg;

    // Bus register window
    localparam logic [1:0] UART_REG_DATA   = 2'd0;
    localparam logic [1:0] UART_REG_STATUS = 2'd1;
    localparam logic [1:0] UART_REG_DIV_LO = 2'd2;
    localparam logic [1:0] UART_REG_DIV_HI = 2'd3;

    // STATUS register bit positions
    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_EMPTY    = 1;
    localparam int STAT_TX_FULL     = 2;
    localparam int STAT_TX_OVF      = 3;
    localparam int STAT_RX_OVR      = 4;

    typedef enum logic [1:0] {
        TX_IDLE   = 2'd0,
        TX_LAUNCH = 2'd1,
        TX_WAIT   = 2'd2
    } tx_state_t;

    typedef enum logic [0:0] {
        RX_IDLE = 1'b0,
        RX_ACK  = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/vliw_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_sync_fifo
//  Description : Single-clock FIFO with first-word-fall-through head output.
//                Pointers carry one extra wrap bit to separate full/empty.
//                A pop from a full FIFO lets a same-cycle push succeed.
//  Revision    : 1.0  initial release
// ============================================================================
module vliw_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wptr == r_rptr);
    assign full      = (r_wptr[AW] != r_rptr[AW]) &&
                       (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);
    assign head      = r_mem[r_rptr[AW-1:0]];

    // Pointer update; reset discards all contents
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_do_push) r_wptr <= r_wptr + 1'b1;
            if (w_do_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    // Storage write; slot contents need no reset since pointers guard them
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wptr[AW-1:0]] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/vliw_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vliw_uart_ctrl
//  Description : CPU-facing front end for the vliw_uart core. TX/RX FIFOs,
//                baud divisor register and a 4-register bus window.
//  Revision    : 1.0  initial release
// ============================================================================
module vliw_uart_ctrl
    import vliw_uart_pkg::*;
#(
    parameter int          TX_DEPTH  = 8,
    parameter int          RX_DEPTH  = 8,
    parameter logic [15:0] DIV_RESET = 16'd103
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        we,
    input  logic        re,
    output logic [7:0]  rdata,
    output logic        irq,
    output logic [15:0] divisor,
    output logic [7:0]  uart_din,
    output logic        uart_start,
    input  logic        uart_busy,
    input  logic [7:0]  uart_dout,
    input  logic        uart_has_byte,
    output logic        uart_clr_hb
);
    tx_state_t   r_tx_state, w_tx_next;
    rx_state_t   r_rx_state, w_rx_next;

    logic        w_wr_data, w_rd_data, w_wr_stat;
    logic        w_tx_full, w_tx_empty, w_tx_pop;
    logic [7:0]  w_tx_head;
    logic        w_rx_full, w_rx_empty, w_rx_push;
    logic [7:0]  w_rx_head;
    logic        w_tx_ovf_set, w_rx_ovr_set;
    logic [7:0]  w_status;

    logic [7:0]  r_rdata;
    logic [15:0] r_divisor;
    logic [7:0]  r_uart_din;
    logic        r_uart_start;
    logic        r_clr_hb;
    logic        r_tx_ovf;
    logic        r_rx_ovr;

    assign w_wr_data = we && (addr == UART_REG_DATA);
    assign w_rd_data = re && (addr == UART_REG_DATA);
    assign w_wr_stat = we && (addr == UART_REG_STATUS);

    // A push into a full FIFO is lost unless the same cycle also pops it
    assign w_tx_ovf_set = w_wr_data && w_tx_full && !w_tx_pop;
    assign w_rx_ovr_set = w_rx_push && w_rx_full && !w_rd_data;

    always_comb begin
        w_status                   = 8'h00;
        w_status[STAT_RX_NONEMPTY] = !w_rx_empty;
        w_status[STAT_TX_EMPTY]    = w_tx_empty;
        w_status[STAT_TX_FULL]     = w_tx_full;
        w_status[STAT_TX_OVF]      = r_tx_ovf;
        w_status[STAT_RX_OVR]      = r_rx_ovr;
    end

    vliw_sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_wr_data),
        .pop   (w_tx_pop),
        .din   (wdata),
        .full  (w_tx_full),
        .empty (w_tx_empty),
        .head  (w_tx_head)
    );

    vliw_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rx_push),
        .pop   (w_rd_data),
        .din   (uart_dout),
        .full  (w_rx_full),
        .empty (w_rx_empty),
        .head  (w_rx_head)
    );

    // TX next state: launch from IDLE, then wait for busy to rise and fall
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (!w_tx_empty) begin
                    w_tx_pop  = 1'b1;
                    w_tx_next = TX_LAUNCH;
                end
            end
            // busy lags start by two cycles; stay here until it is seen
            TX_LAUNCH: if (uart_busy)  w_tx_next = TX_WAIT;
            TX_WAIT:   if (!uart_busy) w_tx_next = TX_IDLE;
            default:   w_tx_next = TX_IDLE;
        endcase
    end

    // RX next state: capture once, then skip the cycle has_byte is still high
    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_push = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (uart_has_byte) begin
                    w_rx_push = 1'b1;
                    w_rx_next = RX_ACK;
                end
            end
            RX_ACK:  w_rx_next = RX_IDLE;
            default: w_rx_next = RX_IDLE;
        endcase
    end

    // FSM state registers and core handshake outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_state   <= TX_IDLE;
            r_rx_state   <= RX_IDLE;
            r_uart_start <= 1'b0;
            r_uart_din   <= 8'h00;
            r_clr_hb     <= 1'b0;
        end else begin
            r_tx_state   <= w_tx_next;
            r_rx_state   <= w_rx_next;
            r_uart_start <= w_tx_pop;
            r_clr_hb     <= w_rx_push;
            if (w_tx_pop) r_uart_din <= w_tx_head;
        end
    end

    // Register file: divisor halves, sticky flags (set beats clear), read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_divisor <= DIV_RESET;
            r_tx_ovf  <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_rdata   <= 8'h00;
        end else begin
            if (we && addr == UART_REG_DIV_LO) r_divisor[7:0]  <= wdata;
            if (we && addr == UART_REG_DIV_HI) r_divisor[15:8] <= wdata;
            if (w_wr_stat && wdata[STAT_TX_OVF]) r_tx_ovf <= 1'b0;
            if (w_wr_stat && wdata[STAT_RX_OVR]) r_rx_ovr <= 1'b0;
            if (w_tx_ovf_set) r_tx_ovf <= 1'b1;
            if (w_rx_ovr_set) r_rx_ovr <= 1'b1;
            if (re) begin
                case (addr)
                    UART_REG_DATA:   r_rdata <= w_rx_empty ? 8'h00 : w_rx_head;
                    UART_REG_STATUS: r_rdata <= w_status;
                    UART_REG_DIV_LO: r_rdata <= r_divisor[7:0];
                    default:         r_rdata <= r_divisor[15:8];
                endcase
            end
        end
    end

    assign rdata       = r_rdata;
    assign irq         = !w_rx_empty;
    assign divisor     = r_divisor;
    assign uart_din    = r_uart_din;
    assign uart_start  = r_uart_start;
    assign uart_clr_hb = r_clr_hb;

endmodule
`default_nettype wire

// File: tb/tb_vliw_uart_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vliw_uart_ctrl
//  Description : Self-checking bench for vliw_uart_ctrl with a behavioural
//                stand-in for the serial core's start/busy handshake.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vliw_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic [7:0]  wdata;
    logic        we, re;
    logic [7:0]  rdata;
    logic        irq;
    logic [15:0] divisor;
    logic [7:0]  uart_din;
    logic        uart_start;
    logic        uart_busy;
    logic [7:0]  uart_dout;
    logic        uart_has_byte;
    logic        uart_clr_hb;

    int checks   = 0;
    int failures = 0;

    // Core stand-in state
    logic [7:0] tx_log[$];
    int         busy_len    = 12;
    int         overlap_err = 0;
    int         clr_cnt     = 0;
    int         bcnt        = 0;
    int         dly         = 0;
    bit         in_flight   = 1'b0;

    vliw_uart_ctrl #(.TX_DEPTH(8), .RX_DEPTH(8), .DIV_RESET(16'd103)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .irq           (irq),
        .divisor       (divisor),
        .uart_din      (uart_din),
        .uart_start    (uart_start),
        .uart_busy     (uart_busy),
        .uart_dout     (uart_dout),
        .uart_has_byte (uart_has_byte),
        .uart_clr_hb   (uart_clr_hb)
    );

    always #5 clk = ~clk;

    // Core model: logs each start, raises busy two cycles later for busy_len cycles
    always @(posedge clk) begin
        if (rst) begin
            uart_busy <= 1'b0;
            in_flight = 1'b0;
            dly       = 0;
            bcnt      = 0;
        end else if (uart_start) begin
            tx_log.push_back(uart_din);
            if (in_flight) overlap_err++;
            in_flight = 1'b1;
            dly       = 1;
        end else if (dly > 0) begin
            dly = 0;
            uart_busy <= 1'b1;
            bcnt = busy_len;
        end else if (uart_busy) begin
            bcnt--;
            if (bcnt <= 0) begin
                uart_busy <= 1'b0;
                in_flight = 1'b0;
            end
        end
    end

    // Count clr_hb pulses
    always @(posedge clk) if (uart_clr_hb === 1'b1) clr_cnt++;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
        @(negedge clk); addr = a; wdata = d; we = 1'b1;
        @(negedge clk); we = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [7:0] d);
        @(negedge clk); addr = a; re = 1'b1;
        @(negedge clk); re = 1'b0; d = rdata;
    endtask

    // Present one byte on the core side; has_byte drops two edges later
    task automatic send_rx(input logic [7:0] b);
        @(negedge clk); uart_dout = b; uart_has_byte = 1'b1;
        @(posedge clk);
        @(posedge clk); #1 uart_has_byte = 1'b0;
    endtask

    task automatic wait_log(input int n, input int limit, input string name);
        int i = 0;
        while (tx_log.size() < n && i < limit) begin @(negedge clk); i++; end
        if (tx_log.size() < n) begin
            checks++; failures++;
            $display("FAIL %s: timeout, log size %0d required %0d", name, tx_log.size(), n);
        end
    endtask

    task automatic wait_busy(input int limit, input string name);
        int i = 0;
        while (uart_busy !== 1'b1 && i < limit) begin @(negedge clk); i++; end
        if (uart_busy !== 1'b1) begin
            checks++; failures++;
            $display("FAIL %s: timeout waiting for busy", name);
        end
    endtask

    typedef struct {
        logic        we;
        logic        re;
        logic [1:0]  addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rd;
        logic [15:0] exp_div;
    } vec_t;

    vec_t vecs[12];

    initial begin
        logic [7:0] d;
        int base;

        vecs[0]  = '{1'b1, 1'b0, 2'd2, 8'h34, 8'h00, 16'h0034};
        vecs[1]  = '{1'b1, 1'b0, 2'd3, 8'h12, 8'h00, 16'h1234};
        vecs[2]  = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h34, 16'h1234};
        vecs[3]  = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h12, 16'h1234};
        vecs[4]  = '{1'b1, 1'b1, 2'd3, 8'h00, 8'h12, 16'h0034};
        vecs[5]  = '{1'b0, 1'b1, 2'd3, 8'h00, 8'h00, 16'h0034};
        vecs[6]  = '{1'b1, 1'b0, 2'd2, 8'h04, 8'h00, 16'h0004};
        vecs[7]  = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h02, 16'h0004};
        vecs[8]  = '{1'b0, 1'b1, 2'd0, 8'h00, 8'h00, 16'h0004};
        vecs[9]  = '{1'b1, 1'b0, 2'd1, 8'hE7, 8'h00, 16'h0004};
        vecs[10] = '{1'b0, 1'b1, 2'd1, 8'h00, 8'h02, 16'h0004};
        vecs[11] = '{1'b0, 1'b1, 2'd2, 8'h00, 8'h04, 16'h0004};

        rst = 1'b1; addr = 2'd0; wdata = 8'h00; we = 1'b0; re = 1'b0;
        uart_dout = 8'h00; uart_has_byte = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_rdata", rdata, 8'h00);
        check("rst_irq", irq, 1'b0);
        check("rst_divisor", divisor, 16'd103);
        check("rst_din", uart_din, 8'h00);
        check("rst_start", uart_start, 1'b0);
        check("rst_clr_hb", uart_clr_hb, 1'b0);
        bus_read(2'd1, d); check("rst_status", d, 8'h02);
        bus_read(2'd2, d); check("rst_div_lo", d, 8'h67);
        bus_read(2'd3, d); check("rst_div_hi", d, 8'h00);

        // Register window vectors
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            addr = vecs[i].addr; wdata = vecs[i].wdata; we = vecs[i].we; re = vecs[i].re;
            @(negedge clk);
            we = 1'b0; re = 1'b0;
            check($sformatf("vec%0d_div", i), divisor, vecs[i].exp_div);
            if (vecs[i].re) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
        end

        // TX of "ABC": first launch latency, then ordered non-overlapping starts
        base = tx_log.size();
        bus_write(2'd0, 8'h41);
        @(negedge clk);
        check("tx_start_pulse", uart_start, 1'b1);
        check("tx_start_din", uart_din, 8'h41);
        @(negedge clk);
        check("tx_start_one_cycle", uart_start, 1'b0);
        bus_write(2'd0, 8'h42);
        bus_write(2'd0, 8'h43);
        wait_log(base + 3, 2000, "tx_abc");
        repeat (busy_len + 20) @(negedge clk);
        check("tx_abc_count", tx_log.size(), base + 3);
        if (tx_log.size() >= base + 3) begin
            check("tx_abc_0", tx_log[base], 8'h41);
            check("tx_abc_1", tx_log[base + 1], 8'h42);
            check("tx_abc_2", tx_log[base + 2], 8'h43);
        end
        check("tx_din_hold", uart_din, 8'h43);

        // TX overflow while the core is busy
        busy_len = 400;
        base = tx_log.size();
        bus_write(2'd0, 8'h70);
        wait_busy(20, "tx_ovf_busy");
        busy_len = 12;
        for (int i = 0; i < 9; i++) bus_write(2'd0, 8'h60 + 8'(i));
        bus_read(2'd1, d); check("tx_ovf_status", d, 8'h0C);
        bus_write(2'd1, 8'h08);
        bus_read(2'd1, d); check("tx_ovf_cleared", d, 8'h04);
        wait_log(base + 9, 5000, "tx_ovf_drain");
        repeat (60) @(negedge clk);
        check("tx_ovf_count", tx_log.size(), base + 9);
        if (tx_log.size() >= base + 9) begin
            check("tx_ovf_first", tx_log[base], 8'h70);
            for (int i = 0; i < 8; i++)
                check($sformatf("tx_ovf_byte%0d", i), tx_log[base + 1 + i], 8'h60 + 8'(i));
        end
        bus_read(2'd1, d); check("tx_drained_status", d, 8'h02);
        check("tx_no_overlap", overlap_err, 0);

        // Single RX byte
        base = clr_cnt;
        @(negedge clk); uart_dout = 8'h5A; uart_has_byte = 1'b1;
        @(negedge clk);
        check("rx_clr_hb", uart_clr_hb, 1'b1);
        check("rx_irq_rise", irq, 1'b1);
        @(posedge clk); #1 uart_has_byte = 1'b0;
        repeat (3) @(negedge clk);
        check("rx_clr_once", clr_cnt - base, 1);
        bus_read(2'd0, d); check("rx_read", d, 8'h5A);
        check("rx_irq_fall", irq, 1'b0);
        bus_read(2'd0, d); check("rx_read_empty", d, 8'h00);

        // RX overflow: ninth byte discarded
        for (int i = 0; i < 9; i++) send_rx(8'h80 + 8'(i));
        bus_read(2'd1, d); check("rx_ovr_status", d, 8'h13);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, d); check($sformatf("rx_ovr_byte%0d", i), d, 8'h80 + 8'(i));
        end
        bus_read(2'd1, d); check("rx_ovr_sticky", d, 8'h12);
        bus_write(2'd1, 8'h10);
        bus_read(2'd1, d); check("rx_ovr_cleared", d, 8'h02);

        // Full RX FIFO: same-cycle pop and push, no overrun
        for (int i = 0; i < 8; i++) send_rx(8'hC0 + 8'(i));
        @(negedge clk); uart_dout = 8'hC8; uart_has_byte = 1'b1; addr = 2'd0; re = 1'b1;
        @(negedge clk); re = 1'b0;
        check("rx_pushpop_rdata", rdata, 8'hC0);
        @(posedge clk); #1 uart_has_byte = 1'b0;
        bus_read(2'd1, d); check("rx_pushpop_status", d, 8'h03);
        for (int i = 0; i < 8; i++) begin
            bus_read(2'd0, d); check($sformatf("rx_pushpop_byte%0d", i), d, 8'hC1 + 8'(i));
        end

        // Reset in the middle of transmitting 0x55
        send_rx(8'h33);
        busy_len = 200;
        bus_write(2'd0, 8'h55);
        wait_busy(20, "rst_mid_busy");
        bus_write(2'd0, 8'h56);
        bus_write(2'd0, 8'h57);
        bus_write(2'd2, 8'h09);
        base = tx_log.size();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("mid_rst_rdata", rdata, 8'h00);
        check("mid_rst_irq", irq, 1'b0);
        check("mid_rst_divisor", divisor, 16'd103);
        check("mid_rst_din", uart_din, 8'h00);
        check("mid_rst_start", uart_start, 1'b0);
        check("mid_rst_clr_hb", uart_clr_hb, 1'b0);
        bus_read(2'd1, d); check("mid_rst_status", d, 8'h02);
        repeat (60) @(negedge clk);
        check("mid_rst_no_start", tx_log.size(), base);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
